mem_access_stage: RTL

- MEM pipeline stage of the 5-stage MIPS core. Sits between the EX/MEM register and the writeback stage.
- Performs loads and stores to data memory over a req/ack handshake. Does byte/halfword lane steering, sign/zero extension and alignment checking.
- Owns the MEM/WB pipeline register that feeds writeback: ALU result, read data, destination, MemtoReg, RegWrite.
- Raises a stall toward upstream stages while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS core: data-memory req/ack access, lane steering and the MEM/WB register.
// Build macro MEM_TIMEOUT_EN aborts a WAIT that sees no MemAck within TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EXMEMValid,
    input  logic [31:0] EXMEMALUResult,
    input  logic [31:0] EXMEMWriteData,
    input  logic [4:0]  EXMEMDst,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic        EXMEMMemtoReg,
    input  logic        EXMEMRegWrite,
    input  logic [1:0]  EXMEMSize,
    input  logic        EXMEMSignExt,
    output logic        MemReq,
    output logic        MemWe,
    output logic [29:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        MEMStall,
    output logic        MEMMisalign,
    output logic [31:0] MEMWBALUResult,
    output logic [31:0] MEMWBReadData,
    output logic [4:0]  MEMWBDst,
    output logic        MEMWBMemtoReg,
    output logic        MEMWBRegWrite
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  alo_q, alo_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d, load_q, load_d, m2r_cap_q, m2r_cap_d, rw_cap_q, rw_cap_d;
    logic [4:0]  dst_cap_q, dst_cap_d;
    logic [31:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
    logic [4:0]  wb_dst_q, wb_dst_d;
    logic        wb_m2r_q, wb_m2r_d, wb_rw_q, wb_rw_d, mis_q, mis_d;
    logic        memop, misalign, expire;

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_enables = 4'b0001 << a;
            2'b01:   byte_enables = a[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sext,
                                                input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   load_extend = {{24{sext & b[7]}}, b};
            2'b01:   load_extend = {{16{sext & h[15]}}, h};
            default: load_extend = w;
        endcase
    endfunction

    assign memop    = EXMEMValid & (EXMEMMemRead | EXMEMMemWrite);
    assign misalign = ((EXMEMSize == 2'b01) & EXMEMALUResult[0]) |
                      (EXMEMSize[1] & (EXMEMALUResult[1:0] != 2'b00));

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (state_q == WAIT) & ~MemAck & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT && !MemAck)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign expire         = 1'b0;
`endif

    // An aborted access must not stall, otherwise EX/MEM would re-present the same op forever.
    assign MEMStall = ~reset & ((state_q == IDLE) ? (memop & ~misalign) : (~MemAck & ~expire));

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        alo_d      = alo_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sext_d     = sext_q;
        load_d     = load_q;
        m2r_cap_d  = m2r_cap_q;
        rw_cap_d   = rw_cap_q;
        dst_cap_d  = dst_cap_q;
        wb_alu_d   = '0;
        wb_rdata_d = '0;
        wb_dst_d   = '0;
        wb_m2r_d   = 1'b0;
        wb_rw_d    = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop && misalign) begin
                    mis_d = 1'b1;
                end else if (memop) begin
                    state_d   = WAIT;
                    req_d     = 1'b1;
                    we_d      = EXMEMMemWrite;
                    addr_d    = EXMEMALUResult[31:2];
                    alo_d     = EXMEMALUResult[1:0];
                    be_d      = byte_enables(EXMEMSize, EXMEMALUResult[1:0]);
                    wdata_d   = store_lanes(EXMEMSize, EXMEMWriteData);
                    size_d    = EXMEMSize;
                    sext_d    = EXMEMSignExt;
                    load_d    = ~EXMEMMemWrite;
                    m2r_cap_d = EXMEMMemtoReg;
                    rw_cap_d  = EXMEMRegWrite;
                    dst_cap_d = EXMEMDst;
                end else begin
                    wb_alu_d = EXMEMALUResult;
                    wb_dst_d = EXMEMDst;
                    wb_m2r_d = EXMEMMemtoReg;
                    wb_rw_d  = EXMEMRegWrite & EXMEMValid;
                end
            end
            WAIT: begin
                if (MemAck) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_alu_d   = {addr_q, alo_q};
                    wb_dst_d   = dst_cap_q;
                    wb_m2r_d   = m2r_cap_q;
                    wb_rw_d    = load_q & rw_cap_q;
                    wb_rdata_d = load_q ? load_extend(size_q, sext_q, alo_q, MemRData) : '0;
                end else if (expire) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    mis_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            alo_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            load_q     <= 1'b0;
            m2r_cap_q  <= 1'b0;
            rw_cap_q   <= 1'b0;
            dst_cap_q  <= '0;
            wb_alu_q   <= '0;
            wb_rdata_q <= '0;
            wb_dst_q   <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            alo_q      <= alo_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            load_q     <= load_d;
            m2r_cap_q  <= m2r_cap_d;
            rw_cap_q   <= rw_cap_d;
            dst_cap_q  <= dst_cap_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_dst_q   <= wb_dst_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
        end
    end

    assign MemReq         = req_q;
    assign MemWe          = we_q;
    assign MemAddr        = addr_q;
    assign MemByteEn      = be_q;
    assign MemWData       = wdata_q;
    assign MEMMisalign    = mis_q;
    assign MEMWBALUResult = wb_alu_q;
    assign MEMWBReadData  = wb_rdata_q;
    assign MEMWBDst       = wb_dst_q;
    assign MEMWBMemtoReg  = wb_m2r_q;
    assign MEMWBRegWrite  = wb_rw_q;
endmodule
